// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: data-side controller for an external asynchronous 32-bit SRAM.
// Takes the MEM stage request, runs a WAIT-cycle strobe window and returns load data.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ce_i, we_n_i, sel_n_i        request valid, 1=read/0=write, active-low selects (0 = word)
//   addr_i, data_i               byte address, store data (byte stores use [7:0])
//   data_o                       load result (sign-extended for byte loads)
//   done_o                       one-cycle completion pulse
//   stall_o                      combinational pipeline hold
//   sram_addr, sram_data_o       SRAM word address and write data
//   sram_data_oe                 drive enable for the SRAM data bus
//   sram_data_i                  SRAM read data
//   sram_ce_n/oe_n/we_n/be_n     active-low SRAM strobes and byte enables
module data_sram_ctrl #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_n_i,
    input  logic [3:0]        sel_n_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              done_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_data_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int unsigned CntW = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            rd_q;
    logic            byte_q;
    logic [1:0]      lane_q;

    logic            accept;
    logic            last;
    logic [7:0]      rd_byte;
    logic [31:0]     rd_word;

    assign accept = (state_q == StIdle) && ce_i;
    assign last   = (state_q == StAccess) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (ce_i) state_d = StAccess;
            StAccess: if (cnt_q == '0) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs; stall is forced low during reset so the pipeline is never held by stale state
    always_comb begin
        done_o  = (state_q == StDone);
        stall_o = !rst && (accept || (state_q == StAccess));
    end

    // Lane extraction for the result register
    always_comb begin
        rd_byte = sram_data_i[7:0];
        case (lane_q)
            2'd0:    rd_byte = sram_data_i[7:0];
            2'd1:    rd_byte = sram_data_i[15:8];
            2'd2:    rd_byte = sram_data_i[23:16];
            default: rd_byte = sram_data_i[31:24];
        endcase
        rd_word = byte_q ? {{24{rd_byte[7]}}, rd_byte} : sram_data_i;
    end

    // Registered SRAM interface: everything is set at accept and held through ACCESS,
    // then the strobes drop on the edge into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= 2'd0;
            sram_addr    <= '0;
            sram_data_o  <= '0;
            sram_data_oe <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            data_o       <= '0;
        end else if (accept) begin
            cnt_q        <= CntW'(WAIT - 1);
            rd_q         <= we_n_i;
            byte_q       <= (sel_n_i != 4'b0000);
            lane_q       <= addr_i[1:0];
            sram_addr    <= addr_i[ADDR_W+1:2];
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= !we_n_i;
            sram_we_n    <= we_n_i;
            sram_data_oe <= !we_n_i;
            if (sel_n_i != 4'b0000) begin
                sram_be_n   <= ~(4'b0001 << addr_i[1:0]);
                sram_data_o <= {4{data_i[7:0]}};
            end else begin
                sram_be_n   <= 4'b0000;
                sram_data_o <= data_i;
            end
        end else if (last) begin
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            sram_data_oe <= 1'b0;
            if (rd_q) begin
                data_o <= rd_word;
            end
        end else if (state_q == StAccess) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_m;
    logic [1:0]  ce_w;
    logic        we_n;
    logic [3:0]  sel_n;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] m_data_o;
    logic        m_done, m_stall;
    logic [19:0] m_addr;
    logic [31:0] m_dout, m_rdata;
    logic        m_doe, m_ce_n, m_oe_n, m_we_n;
    logic [3:0]  m_be_n;

    logic [1:0]  done_w, stall_w;
    logic [31:0] data_w [2];

    logic [31:0] mem [256];
    int unsigned oc_m = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_ctrl #(.ADDR_W(20), .WAIT(2)) u_dut (
        .clk(clk), .rst(rst), .ce_i(ce_m), .we_n_i(we_n), .sel_n_i(sel_n), .addr_i(addr),
        .data_i(wdata), .data_o(m_data_o), .done_o(m_done), .stall_o(m_stall),
        .sram_addr(m_addr), .sram_data_o(m_dout), .sram_data_oe(m_doe),
        .sram_data_i(m_rdata), .sram_ce_n(m_ce_n), .sram_oe_n(m_oe_n), .sram_we_n(m_we_n),
        .sram_be_n(m_be_n)
    );

    // SRAM model: read data only valid in the last strobe cycle (cycle 2 of 2)
    always @(posedge clk) begin
        if (!m_ce_n && !m_oe_n) oc_m <= oc_m + 1;
        else oc_m <= 0;
        if (!m_ce_n && !m_we_n && m_doe) begin
            for (int b = 0; b < 4; b++) begin
                if (!m_be_n[b]) mem[m_addr[7:0]][b*8 +: 8] = m_dout[b*8 +: 8];
            end
        end
    end
    assign m_rdata = (!m_ce_n && !m_oe_n && oc_m == 1) ? mem[m_addr[7:0]] : 32'h0BAD0BAD;

    // WAIT=1 and WAIT=4 builds, read-only SRAM returning 0xC0DE0000 | word address
    for (genvar g = 0; g < 2; g++) begin : g_wait
        localparam int unsigned WW = (g == 0) ? 1 : 4;
        logic [19:0] a;
        logic [31:0] dout, rdata;
        logic        doe, cen, oen, wen;
        logic [3:0]  ben;
        int unsigned oc = 0;

        data_sram_ctrl #(.ADDR_W(20), .WAIT(WW)) u_dut (
            .clk(clk), .rst(rst), .ce_i(ce_w[g]), .we_n_i(we_n), .sel_n_i(sel_n),
            .addr_i(addr), .data_i(wdata), .data_o(data_w[g]), .done_o(done_w[g]),
            .stall_o(stall_w[g]), .sram_addr(a), .sram_data_o(dout), .sram_data_oe(doe),
            .sram_data_i(rdata), .sram_ce_n(cen), .sram_oe_n(oen), .sram_we_n(wen),
            .sram_be_n(ben)
        );

        always @(posedge clk) begin
            if (!cen && !oen) oc <= oc + 1;
            else oc <= 0;
        end
        assign rdata = (!cen && !oen && oc == WW - 1) ? (32'hC0DE0000 | 32'(a)) : 32'h0BAD0BAD;
    end

    // Drives one request on the WAIT=2 DUT, starting at posedge+1 and ending at posedge+1.
    // Captures the SRAM-side signals in the first ACCESS cycle and the strobe in DONE.
    task automatic run_access(input logic we, input logic [3:0] sel, input logic [31:0] a,
                              input logic [31:0] d, input logic hold, output int lat,
                              output int stalls, output int wecnt, output int done_at,
                              output logic [3:0] be_s, output logic [19:0] addr_s,
                              output logic [31:0] do_s, output logic oen_s, output logic doe_s,
                              output logic cen_done);
        ce_m = 1'b1; we_n = we; sel_n = sel; addr = a; wdata = d;
        lat = -1; stalls = 0; wecnt = 0; done_at = -1;
        be_s = 'x; addr_s = 'x; do_s = 'x; oen_s = 1'bx; doe_s = 1'bx; cen_done = 1'bx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_stall) stalls++;
            if (!m_we_n) wecnt++;
            if (i == 1) begin
                be_s = m_be_n; addr_s = m_addr; do_s = m_dout; oen_s = m_oe_n; doe_s = m_doe;
            end
            if (m_done) begin
                lat = i; done_at = cyc; cen_done = m_ce_n;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!hold) ce_m = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_m = 1'b1; ce_w = 2'b00; we_n = 1'b1; sel_n = 4'h0;
        addr = 32'h0; wdata = 32'h0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        total++; if (m_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", m_stall); end
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", m_done); end
        total++; if ({m_ce_n, m_oe_n, m_we_n, m_be_n} !== 7'h7F) begin
            bad++; $display("FAIL rst_strobes: got %b want 1111111", {m_ce_n, m_oe_n, m_we_n, m_be_n});
        end
        total++; if ({m_addr, m_dout, m_doe, m_data_o} !== 85'h0) begin
            bad++; $display("FAIL rst_bus: addr %h dout %h oe %b data %h want zeros", m_addr, m_dout, m_doe, m_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; ce_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_read();
        int idx;
        mem[8'h10] = 32'hDEADBEEF;
        ce_m = 1'b1; we_n = 1'b1; sel_n = 4'h0; addr = 32'h40;
        for (int t = 0; t <= 3; t++) begin
            @(negedge clk);
            idx = t;
            if (t >= 1 && t <= 2) begin
                total++; if (m_addr !== 20'h10 || m_oe_n !== 1'b0 || m_ce_n !== 1'b0) begin
                    bad++; $display("FAIL wrd_T%0d_bus: addr %h oe_n %b ce_n %b want 10 0 0", idx, m_addr, m_oe_n, m_ce_n);
                end
            end
            total++; if (m_stall !== (t <= 2)) begin
                bad++; $display("FAIL wrd_T%0d_stall: got %b want %b", idx, m_stall, t <= 2);
            end
            total++; if (m_done !== (t == 3)) begin
                bad++; $display("FAIL wrd_T%0d_done: got %b want %b", idx, m_done, t == 3);
            end
            if (t < 3) @(posedge clk);
        end
        total++; if (m_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wrd_data: got %h want deadbeef", m_data_o); end
        total++; if (m_oe_n !== 1'b1 || m_ce_n !== 1'b1) begin bad++; $display("FAIL wrd_done_strobe: oe_n %b ce_n %b want 1 1", m_oe_n, m_ce_n); end
        @(posedge clk); #1; ce_m = 1'b0;
        @(negedge clk);
        total++; if (m_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wrd_hold: got %h want deadbeef", m_data_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_read();
        int lat, st, wc, da;
        logic [3:0] be; logic [19:0] ad; logic [31:0] dd; logic oe, de, cd;
        mem[0] = 32'h12345680;
        run_access(1'b1, 4'b1110, 32'h0, 32'h0, 1'b0, lat, st, wc, da, be, ad, dd, oe, de, cd);
        total++; if (lat !== 3) begin bad++; $display("FAIL brd0_lat: got %0d want 3", lat); end
        total++; if (be !== 4'b1110) begin bad++; $display("FAIL brd0_be: got %b want 1110", be); end
        total++; if (m_data_o !== 32'hFFFFFF80) begin bad++; $display("FAIL brd0_data: got %h want ffffff80", m_data_o); end
        run_access(1'b1, 4'b1110, 32'h3, 32'h0, 1'b0, lat, st, wc, da, be, ad, dd, oe, de, cd);
        total++; if (be !== 4'b0111) begin bad++; $display("FAIL brd3_be: got %b want 0111", be); end
        total++; if (m_data_o !== 32'h00000012) begin bad++; $display("FAIL brd3_data: got %h want 00000012", m_data_o); end
    endtask

    task automatic test_byte_write();
        int lat, st, wc, da;
        logic [3:0] be; logic [19:0] ad; logic [31:0] dd; logic oe, de, cd;
        mem[1] = 32'h11223344;
        run_access(1'b0, 4'b1110, 32'h06, 32'h000000AB, 1'b0, lat, st, wc, da, be, ad, dd, oe, de, cd);
        total++; if (ad !== 20'h1) begin bad++; $display("FAIL bwr_addr: got %h want 1", ad); end
        total++; if (be !== 4'b1011) begin bad++; $display("FAIL bwr_be: got %b want 1011", be); end
        total++; if (dd !== 32'hABABABAB) begin bad++; $display("FAIL bwr_dout: got %h want abababab", dd); end
        total++; if (oe !== 1'b1 || de !== 1'b1) begin bad++; $display("FAIL bwr_oe: oe_n %b data_oe %b want 1 1", oe, de); end
        total++; if (wc !== 2) begin bad++; $display("FAIL bwr_we_cycles: got %0d want 2", wc); end
        total++; if (mem[1] !== 32'h11AB3344) begin bad++; $display("FAIL bwr_mem: got %h want 11ab3344", mem[1]); end
        total++; if (m_data_o !== 32'h00000012) begin bad++; $display("FAIL bwr_keep_data: got %h want 00000012", m_data_o); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, st, wc, d1, d2, extra;
        logic [3:0] be; logic [19:0] ad; logic [31:0] dd; logic oe, de, cd1, cd2;
        mem[8'h20] = 32'h0;
        run_access(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, lat1, st, wc, d1, be, ad, dd, oe, de, cd1);
        run_access(1'b0, 4'h0, 32'h80, 32'hCAFEF00D, 1'b0, lat2, st, wc, d2, be, ad, dd, oe, de, cd2);
        total++; if (d2 - d1 !== 4 || lat1 !== 3 || lat2 !== 3) begin
            bad++; $display("FAIL b2b_spacing: got %0d (lat %0d %0d) want 4", d2 - d1, lat1, lat2);
        end
        total++; if (cd1 !== 1'b1) begin bad++; $display("FAIL b2b_done_ce_n: got %b want 1", cd1); end
        total++; if (mem[8'h20] !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_store: got %h want cafef00d", mem[8'h20]); end
        total++; if (m_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_load: got %h want deadbeef", m_data_o); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_done) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL b2b_dup: got %0d extra done want 0", extra); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dn, lat, st, wc, da;
        logic [3:0] be; logic [19:0] ad; logic [31:0] dd; logic oe, de, cd;
        ce_m = 1'b1; we_n = 1'b1; sel_n = 4'h0; addr = 32'h40;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (m_stall !== 1'b0) begin bad++; $display("FAIL rmid_stall: got %b want 0", m_stall); end
        @(negedge clk);
        total++; if ({m_ce_n, m_oe_n, m_we_n, m_be_n, m_doe, m_done} !== 9'b111111100) begin
            bad++; $display("FAIL rmid_strobes: got %b want 111111100", {m_ce_n, m_oe_n, m_we_n, m_be_n, m_doe, m_done});
        end
        total++; if (m_addr !== 20'h0 || m_data_o !== 32'h0) begin
            bad++; $display("FAIL rmid_regs: addr %h data %h want 0 0", m_addr, m_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; ce_m = 1'b0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m_done) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL rmid_nodone: got %0d want 0", dn); end
        @(posedge clk); #1;
        run_access(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, lat, st, wc, da, be, ad, dd, oe, de, cd);
        total++; if (lat !== 3 || m_data_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rmid_recover: lat %0d data %h want 3 deadbeef", lat, m_data_o);
        end
        total++; if (st !== 3) begin bad++; $display("FAIL rmid_stall_len: got %0d want 3", st); end
    endtask

    task automatic test_wait_build(input int k, input int ww);
        int stalls, lat;
        ce_w[k] = 1'b1; we_n = 1'b1; sel_n = 4'h0; addr = 32'h14;
        stalls = 0; lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (stall_w[k]) stalls++;
            if (done_w[k]) begin lat = i; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ce_w[k] = 1'b0;
        total++; if (stalls !== ww + 1) begin bad++; $display("FAIL wait%0d_stall: got %0d want %0d", ww, stalls, ww + 1); end
        total++; if (lat !== ww + 1) begin bad++; $display("FAIL wait%0d_lat: got %0d want %0d", ww, lat, ww + 1); end
        total++; if (data_w[k] !== 32'hC0DE0005) begin bad++; $display("FAIL wait%0d_data: got %h want c0de0005", ww, data_w[k]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_word_read();
        test_byte_read();
        test_byte_write();
        test_back_to_back();
        test_reset_mid();
        test_wait_build(0, 1);
        test_wait_build(1, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
